// File: rtl/video_pattern_gen_if.sv
// Video output bundle (vs/hs/de + RGB) from the pattern generator to the filter.
interface video_pattern_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  vs;
    logic                  hs;
    logic                  de;
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;

    modport master (output vs, hs, de, r, g, b);
    modport slave  (input  vs, hs, de, r, g, b);
endinterface

// File: rtl/video_pattern_gen.sv
// Test video source: vs/hs/de timing plus H-ramp / V-ramp / solid / checkerboard RGB.
// Optional PATGEN_FRAME_SHIFT_EN adds o_frame_cnt and makes the ramps move frame to frame.
module video_pattern_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int CNT_WIDTH   = 12,
    parameter int PORCH_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_start,
    input  logic                    i_continuous,
    input  logic [CNT_WIDTH-1:0]    i_hact,
    input  logic [CNT_WIDTH-1:0]    i_vact,
    input  logic [PORCH_WIDTH-1:0]  i_hbp,
    input  logic [PORCH_WIDTH-1:0]  i_hfp,
    input  logic [PORCH_WIDTH-1:0]  i_vbp,
    input  logic [PORCH_WIDTH-1:0]  i_vfp,
    input  logic [1:0]              i_mode,
    input  logic [3*DATA_WIDTH-1:0] i_color,
    video_pattern_gen_if.master     o_vid,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_err
`ifdef PATGEN_FRAME_SHIFT_EN
    ,
    output logic [15:0]             o_frame_cnt
`endif
);
    localparam int AW = CNT_WIDTH + 1;
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  r_state;
    logic                    r_arm;
    logic [CNT_WIDTH-1:0]    r_hact, r_vact;
    logic [PORCH_WIDTH-1:0]  r_hbp, r_hfp, r_vbp, r_vfp;
    logic [1:0]              r_mode;
    logic [3*DATA_WIDTH-1:0] r_color;
    logic [AW-1:0]           r_hcnt, r_vcnt;

    logic                    w_valid, w_start_ok, w_last, w_load, w_stop;
    logic [AW-1:0]           w_rhl, w_rvl;
    logic [CNT_WIDTH-1:0]    w_hact, w_vact;
    logic [PORCH_WIDTH-1:0]  w_hbp, w_hfp, w_vbp, w_vfp;
    logic [1:0]              w_mode;
    logic [3*DATA_WIDTH-1:0] w_color;
    logic [AW-1:0]           w_hl, w_vl, w_nh, w_nv, w_x, w_y;
    logic                    w_de, w_done;
    logic [DATA_WIDTH-1:0]   w_xr, w_yr, w_r, w_g, w_b;

    assign w_valid    = (i_hact != '0) && (i_vact != '0) && (i_hbp != '0) && (i_vbp != '0);
    // r_arm blocks a start sampled on the first edge after reset release
    assign w_start_ok = (r_state == IDLE) && i_start && r_arm;

    assign w_rhl  = AW'(r_hbp) + AW'(r_hact) + AW'(r_hfp);
    assign w_rvl  = AW'(r_vbp) + AW'(r_vact) + AW'(r_vfp);
    assign w_last = (r_hcnt == w_rhl - ONE) && (r_vcnt == w_rvl - ONE);

    // A continuous restart with an unusable config ends the run instead of looping on it
    assign w_load = (w_start_ok && w_valid) ||
                    ((r_state == RUN) && w_last && i_continuous && w_valid);
    assign w_stop = (r_state == RUN) && w_last && !(i_continuous && w_valid);

    // Fresh config applies to the very first cycle of a (re)started frame
    assign w_hact  = w_load ? i_hact  : r_hact;
    assign w_vact  = w_load ? i_vact  : r_vact;
    assign w_hbp   = w_load ? i_hbp   : r_hbp;
    assign w_hfp   = w_load ? i_hfp   : r_hfp;
    assign w_vbp   = w_load ? i_vbp   : r_vbp;
    assign w_vfp   = w_load ? i_vfp   : r_vfp;
    assign w_mode  = w_load ? i_mode  : r_mode;
    assign w_color = w_load ? i_color : r_color;

    always_comb begin
        w_nh = '0;
        w_nv = '0;
        if (!w_load) begin
            if (r_hcnt == w_rhl - ONE) begin
                w_nv = (r_vcnt == w_rvl - ONE) ? '0 : r_vcnt + ONE;
            end else begin
                w_nh = r_hcnt + ONE;
                w_nv = r_vcnt;
            end
        end
    end

    assign w_hl   = AW'(w_hbp) + AW'(w_hact) + AW'(w_hfp);
    assign w_vl   = AW'(w_vbp) + AW'(w_vact) + AW'(w_vfp);
    assign w_done = (w_nh == w_hl - ONE) && (w_nv == w_vl - ONE);
    assign w_x    = w_nh - AW'(w_hbp);
    assign w_y    = w_nv - AW'(w_vbp);
    assign w_de   = (w_nh >= AW'(w_hbp)) && (w_nh < AW'(w_hbp) + AW'(w_hact)) &&
                    (w_nv >= AW'(w_vbp)) && (w_nv < AW'(w_vbp) + AW'(w_vact));

`ifdef PATGEN_FRAME_SHIFT_EN
    logic [15:0] w_fcnt;
    // Count as it will read once any pending frame_done has been absorbed
    assign w_fcnt = o_frame_cnt + {15'd0, o_frame_done};
    assign w_xr   = DATA_WIDTH'(w_x) + DATA_WIDTH'(w_fcnt);
    assign w_yr   = DATA_WIDTH'(w_y) + DATA_WIDTH'(w_fcnt);
`else
    assign w_xr   = DATA_WIDTH'(w_x);
    assign w_yr   = DATA_WIDTH'(w_y);
`endif

    always_comb begin
        {w_r, w_g, w_b} = '0;
        if (w_de) begin
            case (w_mode)
                2'd0:    {w_r, w_g, w_b} = {3{w_xr}};
                2'd1:    {w_r, w_g, w_b} = {3{w_yr}};
                2'd2:    {w_r, w_g, w_b} = w_color;
                default: {w_r, w_g, w_b} = (w_x[3] ^ w_y[3]) ? {(3*DATA_WIDTH){1'b1}} : '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_arm        <= 1'b0;
            {r_hact, r_vact, r_hbp, r_hfp, r_vbp, r_vfp} <= '0;
            r_mode       <= '0;
            r_color      <= '0;
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            o_vid.vs     <= 1'b0;
            o_vid.hs     <= 1'b0;
            o_vid.de     <= 1'b0;
            o_vid.r      <= '0;
            o_vid.g      <= '0;
            o_vid.b      <= '0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
`ifdef PATGEN_FRAME_SHIFT_EN
            o_frame_cnt  <= '0;
`endif
        end else begin
            r_arm <= 1'b1;
            o_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    o_err <= w_start_ok && !w_valid;
                    if (w_load) r_state <= RUN;
                end
                RUN:  if (w_stop) r_state <= IDLE;
            endcase
            if (w_load) begin
                {r_hact, r_vact, r_hbp, r_hfp, r_vbp, r_vfp} <=
                    {i_hact, i_vact, i_hbp, i_hfp, i_vbp, i_vfp};
                r_mode  <= i_mode;
                r_color <= i_color;
            end
            if (w_load || ((r_state == RUN) && !w_stop)) begin
                r_hcnt       <= w_nh;
                r_vcnt       <= w_nv;
                o_vid.vs     <= (w_nv == '0);
                o_vid.hs     <= (w_nh == '0);
                o_vid.de     <= w_de;
                o_vid.r      <= w_r;
                o_vid.g      <= w_g;
                o_vid.b      <= w_b;
                o_busy       <= 1'b1;
                o_frame_done <= w_done;
            end else begin
                r_hcnt       <= '0;
                r_vcnt       <= '0;
                o_vid.vs     <= 1'b0;
                o_vid.hs     <= 1'b0;
                o_vid.de     <= 1'b0;
                o_vid.r      <= '0;
                o_vid.g      <= '0;
                o_vid.b      <= '0;
                o_busy       <= 1'b0;
                o_frame_done <= 1'b0;
            end
`ifdef PATGEN_FRAME_SHIFT_EN
            o_frame_cnt <= o_frame_cnt + {15'd0, o_frame_done};
`endif
        end
    end
endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen: every output cycle compared against a raster model.
module tb_video_pattern_gen;
    localparam int DW = 8;
    localparam int CW = 12;
    localparam int PW = 8;

    logic clk = 1'b0, rstn = 1'b1, i_start = 1'b0, i_continuous = 1'b0;
    logic [CW-1:0]   i_hact = '0, i_vact = '0;
    logic [PW-1:0]   i_hbp = '0, i_hfp = '0, i_vbp = '0, i_vfp = '0;
    logic [1:0]      i_mode = '0;
    logic [3*DW-1:0] i_color = '0;
    logic            o_busy, o_frame_done, o_err;
`ifdef PATGEN_FRAME_SHIFT_EN
    logic [15:0]     o_frame_cnt;
`endif

    video_pattern_gen_if #(.DATA_WIDTH(DW)) vid ();

    video_pattern_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .PORCH_WIDTH(PW)) dut (
        .clk(clk), .rstn(rstn), .i_start(i_start), .i_continuous(i_continuous),
        .i_hact(i_hact), .i_vact(i_vact), .i_hbp(i_hbp), .i_hfp(i_hfp),
        .i_vbp(i_vbp), .i_vfp(i_vfp), .i_mode(i_mode), .i_color(i_color),
        .o_vid(vid), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
`ifdef PATGEN_FRAME_SHIFT_EN
        , .o_frame_cnt(o_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int c_hact, c_vact, c_hbp, c_hfp, c_vbp, c_vfp, c_mode;
    logic [3*DW-1:0] c_color;
    int fcnt = 0;
    int busy_n, de_n;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cfg();
        i_hact = CW'(c_hact); i_vact = CW'(c_vact);
        i_hbp  = PW'(c_hbp);  i_hfp  = PW'(c_hfp);
        i_vbp  = PW'(c_vbp);  i_vfp  = PW'(c_vfp);
        i_mode = 2'(c_mode);  i_color = c_color;
    endtask

    task automatic scramble();
        i_hact = CW'($urandom_range(0, 4095)); i_vact = CW'($urandom_range(0, 4095));
        i_hbp  = PW'($urandom_range(0, 255));  i_hfp  = PW'($urandom_range(0, 255));
        i_vbp  = PW'($urandom_range(0, 255));  i_vfp  = PW'($urandom_range(0, 255));
        i_mode = 2'($urandom_range(0, 3));     i_color = 24'($urandom);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " idle"}, {vid.vs, vid.hs, vid.de, o_busy, o_frame_done, o_err,
                             vid.r, vid.g, vid.b}, 64'd0);
    endtask

    // Expected output at raster position (h,v) straight from the pattern rules
    task automatic check_pos(input int h, input int v, input bit last, input string tag);
        int x, y, shift;
        bit de;
        logic [DW-1:0] p;
        logic [3*DW-1:0] rgb;
        x = h - c_hbp;
        y = v - c_vbp;
        de = (x >= 0) && (x < c_hact) && (y >= 0) && (y < c_vact);
        shift = 0;
`ifdef PATGEN_FRAME_SHIFT_EN
        shift = fcnt;
        chk({tag, " frame_cnt"}, 64'(o_frame_cnt), 64'(fcnt));
`endif
        rgb = '0;
        if (de) begin
            case (c_mode)
                0: begin p = DW'(x + shift); rgb = {p, p, p}; end
                1: begin p = DW'(y + shift); rgb = {p, p, p}; end
                2: rgb = c_color;
                default: rgb = ((((x / 8) ^ (y / 8)) & 1) != 0) ? '1 : '0;
            endcase
        end
        chk({tag, " timing"}, {vid.vs, vid.hs, vid.de, o_busy, o_frame_done, o_err},
            {v == 0, h == 0, de, 1'b1, last, 1'b0});
        chk({tag, " data"}, {vid.r, vid.g, vid.b}, 64'(rgb));
        busy_n += int'(o_busy);
        de_n   += int'(vid.de);
    endtask

    // Entered one half-cycle after the accepting edge; leaves at the first idle cycle
    task automatic run_frames(input int n, input bit scr, input string tag);
        int L, F;
        bit last;
        L = c_hbp + c_hact + c_hfp;
        F = c_vbp + c_vact + c_vfp;
        busy_n = 0; de_n = 0;
        for (int f = 0; f < n; f++)
            for (int v = 0; v < F; v++)
                for (int h = 0; h < L; h++) begin
                    last = (h == L - 1) && (v == F - 1);
                    check_pos(h, v, last, tag);
                    if (last) i_continuous = (f < n - 1);
                    i_start = scr && (f == 0) && (v == 0) && (h == 1);
                    if (scr && n == 1 && v == 0 && h == 2) scramble();
                    @(negedge clk);
                    if (last) fcnt = (fcnt + 1) & 16'hFFFF;
                end
        chk_idle(tag);
    endtask

    task automatic start_pulse();
        drive_cfg();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic set_cfg(input int ha, input int va, input int p, input int m);
        c_hact = ha; c_vact = va; c_hbp = p; c_hfp = p; c_vbp = p; c_vfp = p; c_mode = m;
    endtask

    initial begin
        c_color = 24'h123456;
        set_cfg(4, 2, 3, 0);
        #1 rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle("post-reset");

        // single H-ramp frame
        start_pulse();
        run_frames(1, 1'b0, "t1");
        chk("t1 busy cycles", 64'(busy_n), 64'd80);
        chk("t1 de cycles", 64'(de_n), 64'd8);

        // three back-to-back frames
        i_continuous = 1'b1;
        start_pulse();
        run_frames(3, 1'b0, "t2");
        chk("t2 busy cycles", 64'(busy_n), 64'd240);

        // rejected starts, one bad field at a time
        for (int k = 0; k < 4; k++) begin
            set_cfg(4, 2, 3, 0);
            case (k)
                0: c_hact = 0;
                1: c_vact = 0;
                2: c_hbp = 0;
                default: c_vbp = 0;
            endcase
            start_pulse();
            chk("rej pulse", {o_err, o_busy, vid.vs, vid.hs, vid.de}, 64'b10000);
            @(negedge clk);
            chk_idle("rej after");
        end

        // reset at cycle 40 of a frame, start held across the release
        set_cfg(4, 2, 3, 0);
        start_pulse();
        for (int i = 0; i < 40; i++) begin
            check_pos(i % 10, i / 10, 1'b0, "t4 pre");
            @(negedge clk);
        end
        #2 rstn = 1'b0;
        #1 chk_idle("t4 async");
        fcnt = 0;
        @(negedge clk);
        i_start = 1'b1;
        rstn = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk_idle("t4 start at release");
        repeat (3) @(negedge clk);
        chk_idle("t4 quiet");
        start_pulse();
        run_frames(1, 1'b0, "t4 restart");

        // checkerboard
        set_cfg(32, 16, 3, 3);
        start_pulse();
        run_frames(1, 1'b0, "t5");

        // random geometry / mode, inputs disturbed mid-frame
        for (int k = 0; k < 8; k++) begin
            c_hact = $urandom_range(1, 12); c_vact = $urandom_range(1, 4);
            c_hbp  = $urandom_range(1, 4);  c_hfp  = $urandom_range(0, 3);
            c_vbp  = $urandom_range(1, 3);  c_vfp  = $urandom_range(0, 2);
            c_mode = $urandom_range(0, 3);  c_color = 24'($urandom);
            i_continuous = (k % 2 == 1);
            start_pulse();
            run_frames((k % 2 == 1) ? 2 : 1, (k % 2 == 0), "rand");
        end

`ifdef PATGEN_FRAME_SHIFT_EN
        // moving ramp from a fresh count
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        fcnt = 0;
        @(negedge clk);
        set_cfg(4, 2, 3, 0);
        i_continuous = 1'b1;
        start_pulse();
        run_frames(2, 1'b0, "t6");
        chk("t6 frame_cnt", 64'(o_frame_cnt), 64'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
